// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: ASCII codes, state encoding
// and hex conversion helpers.
package uart_cmd_pkg;

   localparam logic [7:0] ASC_L  = 8'h4C;
   localparam logic [7:0] ASC_l  = 8'h6C;
   localparam logic [7:0] ASC_R  = 8'h52;
   localparam logic [7:0] ASC_r  = 8'h72;
   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_LF = 8'h0A;
   localparam logic [7:0] ASC_O  = 8'h4F;
   localparam logic [7:0] ASC_K  = 8'h4B;
   localparam logic [7:0] ASC_E  = 8'h45;

   typedef enum logic [2:0] {
      IDLE,
      GOT_L,
      GOT_H1,
      GOT_H2,
      GOT_R,
      TX_LOAD,
      TX_WAIT_BUSY,
      TX_WAIT_IDLE
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] nib;
   } hex_nib_t;

   function automatic hex_nib_t hex_to_nib(input logic [7:0] c);
      hex_nib_t r;
      r.valid = 1'b1;
      r.nib   = 4'h0;
      if (c >= 8'h30 && c <= 8'h39)
         r.nib = 4'(c - 8'h30);
      else if (c >= 8'h41 && c <= 8'h46)
         r.nib = 4'(c - 8'h37);
      else if (c >= 8'h61 && c <= 8'h66)
         r.nib = 4'(c - 8'h57);
      else
         r.valid = 1'b0;
      return r;
   endfunction

   // Replies always use uppercase hex.
   function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

endpackage

// File: rtl/uart_reply_tx.sv
// Holds a 4-byte reply and feeds it to the UART transmitter one byte at a time,
// waiting for a full busy->idle cycle of the TX line between strobes.
module uart_reply_tx
   import uart_cmd_pkg::*;
(
   input  logic            clk,
   input  logic            i_rst,
   input  logic            start,
   input  logic [3:0][7:0] bytes,
   input  logic            is_transmitting,
   output logic            transmit,
   output logic [7:0]      tx_byte,
   output logic            done
);

   state_t          state_reg, state_next;
   logic [1:0]      idx_reg, idx_next;
   logic [3:0][7:0] reply_reg;
   logic            transmit_reg;
   logic [7:0]      tx_byte_reg;
   logic            load_reply;
   logic            fire;

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg    <= IDLE;
         idx_reg      <= 2'd0;
         reply_reg    <= '0;
         transmit_reg <= 1'b0;
         tx_byte_reg  <= 8'h00;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         transmit_reg <= fire;
         if (load_reply)
            reply_reg <= bytes;
         // tx_byte only changes on a new strobe, so it stays stable while the UART shifts it out.
         if (fire)
            tx_byte_reg <= reply_reg[idx_reg];
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      load_reply = 1'b0;
      fire       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               load_reply = 1'b1;
               idx_next   = 2'd0;
               state_next = TX_LOAD;
            end
         end
         TX_LOAD: begin
            if (!is_transmitting) begin
               fire       = 1'b1;
               state_next = TX_WAIT_BUSY;
            end
         end
         TX_WAIT_BUSY: begin
            if (is_transmitting)
               state_next = TX_WAIT_IDLE;
         end
         TX_WAIT_IDLE: begin
            if (!is_transmitting) begin
               idx_next = idx_reg + 2'd1;
               if (idx_reg == 2'd3) begin
                  done       = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = TX_LOAD;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign transmit = transmit_reg;
   assign tx_byte  = tx_byte_reg;

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII line-command parser ("Lhh" sets LEDs, "R" reads them) sitting between
// the UART RX and TX ports; replies are sent through uart_reply_tx.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 100_000_000,
   parameter logic [7:0]  LedResetValue = 8'h00
) (
   input  logic       clk,
   input  logic       i_rst,
   input  logic       i_received,
   input  logic [7:0] i_rx_byte,
   input  logic       i_recv_error,
   input  logic       i_is_transmitting,
   output logic       o_transmit,
   output logic [7:0] o_tx_byte,
   output logic [7:0] o_led,
   output logic       o_busy,
   output logic       o_cmd_error,
   output logic       o_rx_dropped
);

   localparam int unsigned CntW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);

   state_t          state_reg, state_next;
   logic [7:0]      led_reg, led_next;
   logic [7:0]      byte_reg, byte_next;
   logic [CntW-1:0] cnt_reg, cnt_next;
   logic            cmd_error_reg, rx_dropped_reg;
   logic            cmd_error, rx_dropped;
   logic            start;
   logic            bad;
   logic [3:0][7:0] reply;
   logic            tx_done;
   hex_nib_t        rx_hex;
   logic            rx_eol;
   logic            timeout_hit;

   assign rx_hex      = hex_to_nib(i_rx_byte);
   assign rx_eol      = (i_rx_byte == ASC_CR) || (i_rx_byte == ASC_LF);
   assign timeout_hit = (TimeoutCycles != 0) && (cnt_reg == CntW'(TimeoutCycles));

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg      <= IDLE;
         led_reg        <= LedResetValue;
         byte_reg       <= 8'h00;
         cnt_reg        <= '0;
         cmd_error_reg  <= 1'b0;
         rx_dropped_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         led_reg        <= led_next;
         byte_reg       <= byte_next;
         cnt_reg        <= cnt_next;
         cmd_error_reg  <= cmd_error;
         rx_dropped_reg <= rx_dropped;
      end
   end

   // TX_LOAD here just means "a reply is owned by uart_reply_tx"; its sub-states live there.
   always_comb begin
      state_next = state_reg;
      led_next   = led_reg;
      byte_next  = byte_reg;
      cnt_next   = cnt_reg;
      start      = 1'b0;
      bad        = 1'b0;
      cmd_error  = 1'b0;
      rx_dropped = 1'b0;
      reply[0]   = ASC_O;
      reply[1]   = ASC_K;
      reply[2]   = ASC_CR;
      reply[3]   = ASC_LF;
      case (state_reg)
         TX_LOAD, TX_WAIT_BUSY, TX_WAIT_IDLE: begin
            rx_dropped = i_received;
            if (tx_done)
               state_next = IDLE;
         end
         default: begin
            if (i_recv_error) begin
               bad = 1'b1;
            end else if (i_received) begin
               cnt_next = '0;
               case (state_reg)
                  IDLE: begin
                     if (i_rx_byte == ASC_L || i_rx_byte == ASC_l)
                        state_next = GOT_L;
                     else if (i_rx_byte == ASC_R || i_rx_byte == ASC_r)
                        state_next = GOT_R;
                     else if (!rx_eol)
                        bad = 1'b1;
                  end
                  GOT_L: begin
                     if (rx_hex.valid) begin
                        byte_next[7:4] = rx_hex.nib;
                        state_next     = GOT_H1;
                     end else begin
                        bad = 1'b1;
                     end
                  end
                  GOT_H1: begin
                     if (rx_hex.valid) begin
                        byte_next[3:0] = rx_hex.nib;
                        state_next     = GOT_H2;
                     end else begin
                        bad = 1'b1;
                     end
                  end
                  GOT_H2: begin
                     if (rx_eol) begin
                        led_next   = byte_reg;
                        start      = 1'b1;
                        state_next = TX_LOAD;
                     end else begin
                        bad = 1'b1;
                     end
                  end
                  GOT_R: begin
                     if (rx_eol) begin
                        reply[0]   = nib_to_hex(led_reg[7:4]);
                        reply[1]   = nib_to_hex(led_reg[3:0]);
                        start      = 1'b1;
                        state_next = TX_LOAD;
                     end else begin
                        bad = 1'b1;
                     end
                  end
                  default: bad = 1'b1;
               endcase
            end else if (state_reg != IDLE) begin
               if (timeout_hit) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CntW'(1);
               end
            end
            if (bad) begin
               reply[0]   = ASC_E;
               reply[1]   = ASC_R;
               reply[2]   = ASC_CR;
               reply[3]   = ASC_LF;
               start      = 1'b1;
               cmd_error  = 1'b1;
               led_next   = led_reg;
               state_next = TX_LOAD;
            end
         end
      endcase
   end

   uart_reply_tx u_reply_tx (
      .clk             (clk),
      .i_rst           (i_rst),
      .start           (start),
      .bytes           (reply),
      .is_transmitting (i_is_transmitting),
      .transmit        (o_transmit),
      .tx_byte         (o_tx_byte),
      .done            (tx_done)
   );

   assign o_led        = led_reg;
   assign o_busy       = (state_reg != IDLE);
   assign o_cmd_error  = cmd_error_reg;
   assign o_rx_dropped = rx_dropped_reg;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected reply bytes are queued when a
// command is driven and compared as the DUT strobes them into a modelled UART.
module tb_uart_cmd_parser;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_received = 1'b0;
   logic [7:0] i_rx_byte = 8'h00;
   logic       i_recv_error = 1'b0;
   logic       i_is_transmitting = 1'b0;
   logic       o_transmit;
   logic [7:0] o_tx_byte;
   logic [7:0] o_led;
   logic       o_busy;
   logic       o_cmd_error;
   logic       o_rx_dropped;

   always #5 clk = ~clk;

   uart_cmd_parser #(
      .TimeoutCycles (50),
      .LedResetValue (8'h00)
   ) dut (
      .clk               (clk),
      .i_rst             (i_rst),
      .i_received        (i_received),
      .i_rx_byte         (i_rx_byte),
      .i_recv_error      (i_recv_error),
      .i_is_transmitting (i_is_transmitting),
      .o_transmit        (o_transmit),
      .o_tx_byte         (o_tx_byte),
      .o_led             (o_led),
      .o_busy            (o_busy),
      .o_cmd_error       (o_cmd_error),
      .o_rx_dropped      (o_rx_dropped)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb_q[$];
   int         busy_cnt = 0;
   int         tx_count = 0;
   int         err_pulses = 0;
   int         drop_pulses = 0;
   logic [7:0] mon_exp;
   logic       mon_was_busy;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // UART model: line busy for 20 cycles after each strobe; also scoreboard compare.
   always @(negedge clk) begin
      mon_was_busy = i_is_transmitting;
      if (o_cmd_error) err_pulses++;
      if (o_rx_dropped) drop_pulses++;
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) i_is_transmitting = 1'b0;
      end
      if (o_transmit) begin
         tx_count++;
         check_val("tx_while_busy", {31'd0, mon_was_busy}, 32'd0);
         if (sb_q.size() == 0) begin
            check_val("tx_unexpected", 32'd1, 32'd0);
         end else begin
            mon_exp = sb_q.pop_front();
            check_val("tx_byte", {24'd0, o_tx_byte}, {24'd0, mon_exp});
         end
         $display("tx byte %02h", o_tx_byte);
         busy_cnt = 20;
         i_is_transmitting = 1'b1;
      end
   end

   task automatic push_reply(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
      sb_q.push_back(b0);
      sb_q.push_back(b1);
      sb_q.push_back(b2);
      sb_q.push_back(b3);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      i_received = 1'b1;
      i_rx_byte  = b;
      $display("rx byte %02h", b);
      @(posedge clk);
      #1;
      i_received = 1'b0;
   endtask

   task automatic send_err();
      @(posedge clk);
      #1;
      i_recv_error = 1'b1;
      $display("rx framing error");
      @(posedge clk);
      #1;
      i_recv_error = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      @(negedge clk);
      while ((o_busy || i_is_transmitting) && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check_val("reply_done_in_time", {31'd0, (n < max_cycles)}, 32'd1);
      check_val("sb_drained", sb_q.size(), 32'd0);
   endtask

   initial begin
      int e0;
      int d0;
      int t0;
      int seen;
      int n;

      repeat (3) @(posedge clk);
      #1;
      i_rst = 1'b0;
      @(negedge clk);
      check_val("rst_led", {24'd0, o_led}, 32'h00);
      check_val("rst_busy", {31'd0, o_busy}, 32'd0);
      check_val("rst_transmit", {31'd0, o_transmit}, 32'd0);
      check_val("rst_cmd_error", {31'd0, o_cmd_error}, 32'd0);
      check_val("rst_rx_dropped", {31'd0, o_rx_dropped}, 32'd0);
      check_val("rst_tx_byte", {24'd0, o_tx_byte}, 32'd0);

      // Set LEDs to A5 and check the EOL-to-strobe latency.
      push_reply("O", "K", 8'h0D, 8'h0A);
      send_byte("L");
      send_byte("A");
      send_byte("5");
      check_val("busy_in_cmd", {31'd0, o_busy}, 32'd1);
      check_val("led_before_eol", {24'd0, o_led}, 32'h00);
      send_byte(8'h0D);
      check_val("led_after_eol", {24'd0, o_led}, 32'hA5);
      @(negedge clk);
      check_val("lat_cycle1", {31'd0, o_transmit}, 32'd0);
      @(negedge clk);
      check_val("lat_cycle2", {31'd0, o_transmit}, 32'd1);
      wait_idle(500);
      check_val("no_err_on_set", err_pulses, 32'd0);

      // Set 3C, then read it back with lowercase r and LF.
      push_reply("O", "K", 8'h0D, 8'h0A);
      send_byte("L"); send_byte("3"); send_byte("C"); send_byte(8'h0A);
      wait_idle(500);
      push_reply("3", "C", 8'h0D, 8'h0A);
      send_byte("r"); send_byte(8'h0A);
      wait_idle(500);
      check_val("led_after_read", {24'd0, o_led}, 32'h3C);

      // Bad hex digit gives ER, LEDs keep their value, next read is normal.
      e0 = err_pulses;
      push_reply("E", "R", 8'h0D, 8'h0A);
      send_byte("L"); send_byte("G");
      wait_idle(500);
      check_val("err_pulse_count", err_pulses - e0, 32'd1);
      check_val("led_after_err", {24'd0, o_led}, 32'h3C);
      push_reply("3", "C", 8'h0D, 8'h0A);
      send_byte("R"); send_byte(8'h0D);
      wait_idle(500);

      // Partial command times out silently.
      t0 = tx_count;
      e0 = err_pulses;
      send_byte("L"); send_byte("1");
      repeat (45) @(negedge clk);
      check_val("timeout_not_yet", {31'd0, o_busy}, 32'd1);
      repeat (10) @(negedge clk);
      check_val("timeout_idle", {31'd0, o_busy}, 32'd0);
      check_val("timeout_no_tx", tx_count - t0, 32'd0);
      check_val("timeout_no_err", err_pulses - e0, 32'd0);
      push_reply("O", "K", 8'h0D, 8'h0A);
      send_byte("L"); send_byte("0"); send_byte("F"); send_byte(8'h0D);
      wait_idle(500);
      check_val("led_after_timeout", {24'd0, o_led}, 32'h0F);

      // Bytes and framing errors during a reply are dropped / ignored.
      push_reply("O", "K", 8'h0D, 8'h0A);
      send_byte("L"); send_byte("7"); send_byte("7"); send_byte(8'h0D);
      d0 = drop_pulses;
      e0 = err_pulses;
      repeat (3) @(posedge clk);
      send_byte("X");
      send_err();
      send_byte("Y");
      send_byte("Z");
      wait_idle(500);
      check_val("drop_count", drop_pulses - d0, 32'd3);
      check_val("drop_no_err", err_pulses - e0, 32'd0);
      check_val("led_after_drop", {24'd0, o_led}, 32'h77);

      // Lowercase command and hex digits; read back as uppercase.
      push_reply("O", "K", 8'h0D, 8'h0A);
      send_byte("l"); send_byte("b"); send_byte("e"); send_byte(8'h0D);
      wait_idle(500);
      check_val("led_lower_hex", {24'd0, o_led}, 32'hBE);
      push_reply("B", "E", 8'h0D, 8'h0A);
      send_byte("R"); send_byte(8'h0D);
      wait_idle(500);

      // Lone EOL in IDLE is harmless; framing error in IDLE gives ER.
      send_byte(8'h0A);
      @(negedge clk);
      check_val("eol_idle_busy", {31'd0, o_busy}, 32'd0);
      e0 = err_pulses;
      push_reply("E", "R", 8'h0D, 8'h0A);
      send_err();
      wait_idle(500);
      check_val("recv_err_pulse", err_pulses - e0, 32'd1);

      // Reset while byte 1 of a reply is in TX_WAIT_BUSY.
      push_reply("B", "E", 8'h0D, 8'h0A);
      send_byte("R"); send_byte(8'h0D);
      seen = 0;
      n = 0;
      while (seen < 2 && n < 300) begin
         @(negedge clk);
         n++;
         if (o_transmit) seen++;
      end
      check_val("reached_byte1", seen, 32'd2);
      i_rst = 1'b1;
      #1;
      sb_q.delete();
      check_val("mid_rst_led", {24'd0, o_led}, 32'h00);
      check_val("mid_rst_busy", {31'd0, o_busy}, 32'd0);
      check_val("mid_rst_transmit", {31'd0, o_transmit}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      i_rst = 1'b0;
      t0 = tx_count;
      repeat (100) @(negedge clk);
      check_val("post_rst_no_tx", tx_count - t0, 32'd0);
      check_val("post_rst_busy", {31'd0, o_busy}, 32'd0);
      check_val("post_rst_led", {24'd0, o_led}, 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
